// File: rtl/demux_2_buf.sv
// demux_2_buf: 2-way stream demultiplexer with one registered slot and a delivery counter per channel
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_in, i_s, i_valid     producer word, destination select, valid
//   o_ready                word accepted this cycle (depends only on i_s and the selected channel)
//   o_out0/1, o_valid0/1   channel data and valid
//   i_ready0/1             channel consumer ready
//   o_cnt0/1               per-channel delivered-word counters (wrap modulo 2^CW)
module demux_2_buf #(
    parameter int N  = 64,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_in,
    input  logic          i_s,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [N-1:0]  o_out0,
    output logic          o_valid0,
    input  logic          i_ready0,
    output logic [N-1:0]  o_out1,
    output logic          o_valid1,
    input  logic          i_ready1,
    output logic [CW-1:0] o_cnt0,
    output logic [CW-1:0] o_cnt1
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t        st0_q, st0_d, st1_q, st1_d;
    logic [N-1:0]  out0_q, out0_d, out1_q, out1_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic          free0, free1, ld0, ld1, xo0, xo1;
    always_comb begin
        xo0     = (st0_q == FULL) && i_ready0;
        xo1     = (st1_q == FULL) && i_ready1;
        // a slot is free if empty or draining this cycle, which gives pass-through
        free0   = (st0_q == EMPTY) || i_ready0;
        free1   = (st1_q == EMPTY) || i_ready1;
        o_ready = i_s ? free1 : free0;
        ld0     = i_valid && o_ready && !i_s;
        ld1     = i_valid && o_ready && i_s;
        st0_d   = ld0 ? FULL : (xo0 ? EMPTY : st0_q);
        st1_d   = ld1 ? FULL : (xo1 ? EMPTY : st1_q);
        out0_d  = ld0 ? i_in : out0_q;
        out1_d  = ld1 ? i_in : out1_q;
        cnt0_d  = cnt0_q + CW'(xo0);
        cnt1_d  = cnt1_q + CW'(xo1);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st0_q  <= EMPTY;
            st1_q  <= EMPTY;
            out0_q <= '0;
            out1_q <= '0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            st0_q  <= st0_d;
            st1_q  <= st1_d;
            out0_q <= out0_d;
            out1_q <= out1_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
    assign o_valid0 = (st0_q == FULL);
    assign o_valid1 = (st1_q == FULL);
    assign o_out0   = out0_q;
    assign o_out1   = out1_q;
    assign o_cnt0   = cnt0_q;
    assign o_cnt1   = cnt1_q;
endmodule

// File: doc/demux_2_buf.md
Name: demux_2_buf

Overview:
- 2-way stream demultiplexer: the inverse of the 2:1 select mux.
- One N-bit input word is steered by i_s into one of two output channels.
- Each channel has a one-entry output register and a valid/ready handshake.
- Sits between a single producer and two independent consumers. Per-channel delivery counters support bring-up and debug.

Parameters:
- N, 64, data width in bits.
- CW, 16, width of each per-channel delivery counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_in  input  N  input data word.
- i_s  input  1  destination select: 0 routes to channel 0, 1 routes to channel 1.
- i_valid  input  1  producer asserts: i_in/i_s valid this cycle.
- o_ready  output  1  block accepts the input word this cycle.
- o_out0  output  N  channel 0 data.
- o_valid0  output  1  channel 0 holds a word.
- i_ready0  input  1  channel 0 consumer accepts.
- o_out1  output  N  channel 1 data.
- o_valid1  output  1  channel 1 holds a word.
- i_ready1  input  1  channel 1 consumer accepts.
- o_cnt0  output  CW  number of words delivered on channel 0.
- o_cnt1  output  CW  number of words delivered on channel 1.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (i_rst sampled on the rising edge of i_clk).
- Reset values: o_valid0 = o_valid1 = 0; o_out0 = o_out1 = 0; o_cnt0 = o_cnt1 = 0. Reset wins over every other event in the same cycle.
- Per-channel state machine (k = 0, 1):
  - EMPTY (o_validk = 0) and FULL (o_validk = 1).
  - slot_free_k = !o_validk || i_readyk.
- o_ready = i_s ? slot_free_1 : slot_free_0.
  - Combinational from i_s, o_validk and i_readyk.
  - Independent of i_valid; no combinational path from i_valid to o_ready.
- Input transfer: occurs when i_valid && o_ready. The word is loaded into channel i_s on that edge.
- Output transfer on channel k: occurs when o_validk && i_readyk.
- Channel k transitions:
  - EMPTY -> FULL on input transfer with i_s = k.
  - FULL -> EMPTY on output transfer with no input transfer to k.
  - FULL -> FULL (new data) on simultaneous output and input transfer to k. This is the pass-through case: full throughput, 1 word per cycle per channel.
  - FULL -> FULL (held) when i_readyk = 0. o_outk must stay bit-stable while o_validk && !i_readyk.
- Latency: a word accepted at edge t is visible on o_outk with o_validk = 1 after edge t (1 cycle). No combinational path from i_in to o_outk.
- Routing:
  - An input transfer never modifies the non-selected channel.
  - A stalled channel never blocks the other channel.
- Data while empty: o_outk holds its last loaded value (0 after reset). Consumers must ignore it while o_validk = 0.
- Counters:
  - o_cntk increments by 1 on each output transfer on channel k.
  - Modulo 2^CW: (2^CW)-1 wraps to 0 with no flag.
  - Both counters may increment in the same cycle.
- Reset mid-operation: held words are discarded, both channels go EMPTY, and counters clear. On the first cycle after reset, o_ready = 1 for either i_s.
- i_s and i_in are don't-care when i_valid = 0. No state changes on input without a transfer.

Test Plan:
- Reset, then i_valid = 1, i_s = 0, i_in = 64'h1234567890ABCDEF, i_ready0 = 1 -> next cycle o_valid0 = 1, o_out0 = 64'h1234567890ABCDEF, o_valid1 = 0. One cycle later o_cnt0 = 1.
- i_s = 1, i_in = 64'hFEDCBA0987654321, i_ready1 = 0 -> o_valid1 = 1, o_out1 = FEDCBA0987654321. Next cycle with i_s = 1: o_ready = 0, and o_out1 is held stable for 5 stall cycles. With i_s = 0 during the stall: o_ready = 1 and channel 0 accepts.
- Back-to-back stream of 8 words alternating i_s = 0/1, i_ready0 = i_ready1 = 1 -> o_ready = 1 every cycle. Each word appears on the correct channel 1 cycle later. Final o_cnt0 = 4, o_cnt1 = 4.
- Channel 0 FULL with i_ready0 = 1 and a new input to channel 0 in the same cycle (i_in = 64'h0 then 64'hFFFFFFFFFFFFFFFF) -> o_valid0 stays 1, o_out0 = FFFFFFFFFFFFFFFF, o_cnt0 increments by 1.
- CW = 4: deliver 17 words on channel 1 -> o_cnt1 goes 15 -> 0 -> 1.
- Assert i_rst while both channels are FULL and stalled -> next cycle o_valid0 = o_valid1 = 0, o_out0 = o_out1 = 0, o_cnt0 = o_cnt1 = 0, o_ready = 1.
